max_pool_relu: RTL and testbench
================================

MAX_POOL_RELU -- requirements
Module: max_pool_relu

Interface
REQ-001 Parameter NUM_TREES, default 2: number of parallel lanes (one per convolution tree).
REQ-002 Parameter IMG_WIDTH, default 8: convolution outputs per feature-map row; even, >=2.
REQ-003 Parameter SHIFT, default 8: requantization right-shift amount, 0..31.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  reset, asynchronous, active-low.
REQ-006 pixel_vector_in  input  32*NUM_TREES  signed 32-bit convolution sums; lane i at [32*i+31:32*i].
REQ-007 in_valid  input  1  pixel_vector_in valid this cycle.
REQ-008 pixel_vector_out  output  8*NUM_TREES  unsigned 8-bit pooled pixels; lane i at [8*i+7:8*i].
REQ-009 out_valid  output  1  pixel_vector_out valid; single-cycle pulse per pooled pixel.

Function
REQ-010 Per lane, per accepted input: ReLU (negative -> 0), arithmetic right shift by SHIFT, saturate to 255.
REQ-011 Input accepted only when in_valid=1; in_valid=0 cycles leave all counters, buffers and state unchanged.
REQ-012 Column counter col counts 0..IMG_WIDTH-1 on accepted inputs; wraps to 0 and toggles row state after IMG_WIDTH-1.
REQ-013 FSM states: ROW_EVEN (reset state), ROW_ODD; ROW_EVEN->ROW_ODD and ROW_ODD->ROW_EVEN only on accepted input at col=IMG_WIDTH-1.
REQ-014 Even col: quantized value held in per-lane pair register.
REQ-015 ROW_EVEN, odd col: max(pair register, current) written to line buffer entry col/2 (IMG_WIDTH/2 entries x NUM_TREES x 8 bits).
REQ-016 ROW_ODD, odd col: result = max(pair register, current, line buffer entry col/2); registered to pixel_vector_out with out_valid=1 the following cycle (latency 1 cycle from accepting input).
REQ-017 out_valid=0 in every other cycle; pixel_vector_out holds last result when out_valid=0.
REQ-018 Output rate: IMG_WIDTH/2 pooled pixels per two input rows; no backpressure.
REQ-019 Max comparisons unsigned on 8-bit quantized values; ties have no effect on result.

Reset
REQ-020 reset=0 asynchronously clears: col=0, state=ROW_EVEN, pair registers=0, pixel_vector_out=0, out_valid=0.
REQ-021 Line buffer contents need no reset; never read before written in the current even row.
REQ-022 Reset mid-row discards the partial window; first output after release follows two complete rows.

Configuration
REQ-023 Macro MAX_POOL_RELU_ROUND_EN defined: add 2^(SHIFT-1) (when SHIFT>0) to the non-negative value before shifting, computed 33-bit, then saturate.
REQ-024 Macro MAX_POOL_RELU_ROUND_EN undefined: truncating shift only; no adder present.

Structure
REQ-025 Shared package holds: pixel width 8, accumulator width 32, FSM state encoding ROW_EVEN/ROW_ODD.
REQ-026 Sub-module relu_requant (ReLU, shift, rounding, saturate; combinational, one 32-bit lane) instantiated NUM_TREES times.
REQ-027 Counters, FSM, pair registers, line buffer and output register reside in max_pool_relu.

Verification (NUM_TREES=2, IMG_WIDTH=4, SHIFT=2, lane 1 = lane 0 + 4 unless stated)
REQ-028 Lane 0 row0 {4,8,12,16}, row1 {20,24,28,32}, continuous valid -> lane0 out 6 one cycle after row1 col1, then 8 after col3; lane1 out 7 then 9; exactly two out_valid pulses.
REQ-029 Lane 0 all inputs -40 -> out 0; lane 0 input 2000 at one position -> that window outputs 255.
REQ-030 Same as REQ-028 with in_valid=0 inserted every other cycle -> identical output values, each out_valid one cycle after its accepting input.
REQ-031 Reset asserted after row0 col2, released, then REQ-028 stimulus -> outputs 6, 8 exactly as REQ-028; no out_valid before row1 col1.
REQ-032 Lane 0 input 6 everywhere -> out 1 without MAX_POOL_RELU_ROUND_EN, 2 with it.
REQ-033 Four rows of REQ-028 pattern repeated -> four out_valid pulses, FSM back in ROW_EVEN, col=0 afterwards.

Source files
------------

// File: rtl/max_pool_relu_pkg.sv
// Shared widths, row-state encoding and an unsigned max helper for the
// max_pool_relu block.
package max_pool_relu_pkg;

  localparam int PIX_W = 8;
  localparam int ACC_W = 32;

  typedef enum logic {
    ROW_EVEN = 1'b0,
    ROW_ODD  = 1'b1
  } row_state_e;

  // Unsigned 8-bit max; on a tie the first operand is returned (same value).
  function automatic logic [PIX_W-1:0] max_u8(input logic [PIX_W-1:0] a,
                                              input logic [PIX_W-1:0] b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/max_pool_relu_relu_requant.sv
// relu_requant: one lane of ReLU, arithmetic right shift by SHIFT and
// saturation to 8 bits. Purely combinational.
// Optional macro MAX_POOL_RELU_ROUND_EN: round-half-up before the shift.
module relu_requant
  import max_pool_relu_pkg::*;
#(
  parameter int SHIFT = 8
) (
  input  logic signed [ACC_W-1:0] acc_in,
  output logic        [PIX_W-1:0] pix_out
);

  logic [ACC_W:0] pos_ext;
  logic [ACC_W:0] shifted;

`ifdef MAX_POOL_RELU_ROUND_EN
  localparam logic [ACC_W:0] ONE = 1;
  // Half an output LSB; zero when there is no shift so nothing is added.
  localparam logic [ACC_W:0] RND = (SHIFT > 0) ? (ONE << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`endif

  // Clamp negatives to zero, scale down, then saturate at 255.
  always_comb begin
    pos_ext = acc_in[ACC_W-1] ? '0 : {1'b0, acc_in};
`ifdef MAX_POOL_RELU_ROUND_EN
    // 33-bit sum so the largest positive input cannot wrap.
    shifted = (pos_ext + RND) >> SHIFT;
`else
    shifted = pos_ext >> SHIFT;
`endif
    pix_out = (|shifted[ACC_W:PIX_W]) ? '1 : shifted[PIX_W-1:0];
  end

endmodule

// File: rtl/max_pool_relu.sv
// max_pool_relu: per-lane ReLU + requantize followed by 2x2 max pooling over
// a streamed feature map, IMG_WIDTH samples per row, no backpressure.
// Optional macro MAX_POOL_RELU_ROUND_EN (in relu_requant): rounding shift.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ROW_EVEN | top row of a pooling window; pair maxima go to line buffer
// ROW_ODD  | bottom row; pair max combined with line buffer, output fires
module max_pool_relu
  import max_pool_relu_pkg::*;
#(
  parameter int NUM_TREES = 2,
  parameter int IMG_WIDTH = 8,
  parameter int SHIFT     = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [ACC_W*NUM_TREES-1:0]   pixel_vector_in,
  input  logic                         in_valid,
  output logic [PIX_W*NUM_TREES-1:0]   pixel_vector_out,
  output logic                         out_valid
);

  localparam int COL_W    = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
  localparam int LB_DEPTH = IMG_WIDTH / 2;
  localparam int LB_IDX_W = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

  typedef logic [NUM_TREES-1:0][PIX_W-1:0] lane_vec_t;

  lane_vec_t        quant;
  lane_vec_t        pair_q, pair_d;
  lane_vec_t        out_q, out_d;
  lane_vec_t        lb_wdata, lb_rdata;
  lane_vec_t        line_buf [LB_DEPTH];
  logic [COL_W-1:0] col_q, col_d;
  row_state_e       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic             lb_we;
  logic [LB_IDX_W-1:0] lb_idx;

  for (genvar i = 0; i < NUM_TREES; i++) begin : g_lane
    relu_requant #(.SHIFT(SHIFT)) u_relu_requant (
      .acc_in (pixel_vector_in[ACC_W*i +: ACC_W]),
      .pix_out(quant[i])
    );
  end

  // Column pair index selects the line buffer slot for both read and write.
  assign lb_idx   = LB_IDX_W'(col_q >> 1);
  assign lb_rdata = line_buf[lb_idx];

  // Next-state: column/row tracking, pair capture, line buffer write, output.
  always_comb begin
    col_d       = col_q;
    state_d     = state_q;
    pair_d      = pair_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    lb_we       = 1'b0;
    lb_wdata    = '0;
    if (in_valid) begin
      if (col_q == COL_LAST) begin
        col_d   = '0;
        state_d = (state_q == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (!col_q[0]) begin
        pair_d = quant;
      end else if (state_q == ROW_EVEN) begin
        lb_we = 1'b1;
        for (int i = 0; i < NUM_TREES; i++) begin
          lb_wdata[i] = max_u8(pair_q[i], quant[i]);
        end
      end else begin
        out_valid_d = 1'b1;
        for (int i = 0; i < NUM_TREES; i++) begin
          out_d[i] = max_u8(max_u8(pair_q[i], quant[i]), lb_rdata[i]);
        end
      end
    end
  end

  // Control and output registers, asynchronously cleared.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_q       <= '0;
      state_q     <= ROW_EVEN;
      pair_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      state_q     <= state_d;
      pair_q      <= pair_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Line buffer: always written in the even row before the odd row reads it.
  always_ff @(posedge clock) begin
    if (lb_we) begin
      line_buf[lb_idx] <= lb_wdata;
    end
  end

  assign pixel_vector_out = out_q;
  assign out_valid        = out_valid_q;

endmodule

// File: tb/tb_max_pool_relu.sv
// Bench for max_pool_relu with NUM_TREES=2, IMG_WIDTH=4, SHIFT=2.
// Lane 1 input is always lane 0 input + 4.
module tb_max_pool_relu;
  import max_pool_relu_pkg::*;

  logic        clock;
  logic        reset;
  logic [63:0] pixel_vector_in;
  logic        in_valid;
  logic [15:0] pixel_vector_out;
  logic        out_valid;

  max_pool_relu #(.NUM_TREES(2), .IMG_WIDTH(4), .SHIFT(2)) dut (
    .clock           (clock),
    .reset           (reset),
    .pixel_vector_in (pixel_vector_in),
    .in_valid        (in_valid),
    .pixel_vector_out(pixel_vector_out),
    .out_valid       (out_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [0:7][31:0] l0;   // lane 0: row0 col0..3, row1 col0..3
    logic [0:1][7:0]  e0;   // lane 0 expected per window
    logic [0:1][7:0]  e1;   // lane 1 expected per window
    bit               gap;  // idle cycle after every accepted input
  } vec_t;

  typedef struct {
    logic [15:0] data;
    int          due;
  } sb_t;

  vec_t        tbl [7];
  sb_t         sb [$];
  int          total = 0;
  int          bad = 0;
  int          pulses = 0;
  logic [15:0] last_out = '0;

  function automatic logic [0:7][31:0] row8(input int v0, v1, v2, v3, v4, v5, v6, v7);
    return {v0, v1, v2, v3, v4, v5, v6, v7};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Advance to the next falling edge and check whatever the DUT shows there.
  task automatic tick();
    sb_t e;
    @(negedge clock);
    if (out_valid) begin
      pulses++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse got=%h want=no_pulse cyc=%0d", pixel_vector_out, cyc);
      end else begin
        e = sb.pop_front();
        chk("pool_data", 32'(pixel_vector_out), 32'(e.data));
        chk("latency", cyc, e.due);
        last_out = e.data;
      end
    end else begin
      if (sb.size() > 0 && cyc > sb[0].due) begin
        total++;
        bad++;
        $display("FAIL missing_pulse got=none want=%h due=%0d", sb[0].data, sb[0].due);
        e = sb.pop_front();
      end
      if (reset) chk("hold_out", 32'(pixel_vector_out), 32'(last_out));
    end
  endtask

  task automatic drive(input int a, input bit push, input logic [15:0] e);
    sb_t n;
    pixel_vector_in = {32'(a + 4), 32'(a)};
    in_valid = 1'b1;
    if (push) begin
      n.data = e;
      n.due  = cyc + 1;
      sb.push_back(n);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic apply_frame(input vec_t v);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        drive(int'($signed(v.l0[r*4+c])), (r == 1) && (c % 2 == 1), {v.e1[c/2], v.e0[c/2]});
        if (v.gap) tick();
      end
    end
  endtask

  initial begin
    int p0;
    tbl[0] = '{l0: row8(4, 8, 12, 16, 20, 24, 28, 32), e0: {8'd6, 8'd8}, e1: {8'd7, 8'd9}, gap: 1'b0};
    tbl[1] = '{l0: row8(4, 8, 12, 16, 20, 24, 28, 32), e0: {8'd6, 8'd8}, e1: {8'd7, 8'd9}, gap: 1'b1};
    tbl[2] = '{l0: row8(-40, -40, -40, -40, -40, -40, -40, -40), e0: {8'd0, 8'd0}, e1: {8'd0, 8'd0}, gap: 1'b0};
    tbl[3] = '{l0: row8(-40, -40, -40, -40, -40, -40, 2000, -40), e0: {8'd0, 8'd255}, e1: {8'd0, 8'd255}, gap: 1'b0};
`ifdef MAX_POOL_RELU_ROUND_EN
    tbl[4] = '{l0: row8(6, 6, 6, 6, 6, 6, 6, 6), e0: {8'd2, 8'd2}, e1: {8'd3, 8'd3}, gap: 1'b0};
`else
    tbl[4] = '{l0: row8(6, 6, 6, 6, 6, 6, 6, 6), e0: {8'd1, 8'd1}, e1: {8'd2, 8'd2}, gap: 1'b0};
`endif
    tbl[5] = '{l0: row8(800, 4, 1000, 4, 4, 4, 4, 4), e0: {8'd200, 8'd250}, e1: {8'd201, 8'd251}, gap: 1'b0};
    tbl[6] = '{l0: row8(4, 4, 4, 4, 400, 4, 4, -1), e0: {8'd100, 8'd1}, e1: {8'd101, 8'd2}, gap: 1'b0};

    pixel_vector_in = '0;
    in_valid = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) tick();
    chk("rst_out", 32'(pixel_vector_out), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(ROW_EVEN));
    chk("rst_col", 32'(dut.col_q), 32'h0);
    reset = 1'b1;
    tick();

    for (int k = 0; k < 7; k++) begin
      p0 = pulses;
      apply_frame(tbl[k]);
      tick();
      chk("pulse_count", pulses - p0, 2);
    end

    // Idle cycles must not move the position.
    repeat (5) tick();
    chk("idle_state", 32'(dut.state_q), 32'(ROW_EVEN));
    chk("idle_col", 32'(dut.col_q), 32'h0);

    // Reset in the middle of the first row discards the partial window.
    drive(4, 1'b0, '0);
    drive(8, 1'b0, '0);
    drive(12, 1'b0, '0);
    #2 reset = 1'b0;
    #1;
    chk("midrst_out", 32'(pixel_vector_out), 32'h0);
    chk("midrst_valid", 32'(out_valid), 32'h0);
    last_out = '0;
    tick();
    reset = 1'b1;
    p0 = pulses;
    apply_frame(tbl[0]);
    tick();
    chk("midrst_pulses", pulses - p0, 2);

    // Four consecutive rows: two full window rows, back to the start.
    p0 = pulses;
    apply_frame(tbl[0]);
    apply_frame(tbl[0]);
    tick();
    chk("four_row_pulses", pulses - p0, 4);
    chk("four_row_state", 32'(dut.state_q), 32'(ROW_EVEN));
    chk("four_row_col", 32'(dut.col_q), 32'h0);

    repeat (4) tick();
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
